// File: rtl/aes_block_reader.sv
// Fetches one 16-byte block from the 64x8 state RAM, one byte per cycle, and hands it to the AES core over a valid/ready handshake.
// Optional macro AES_BLOCK_READER_STREAM_EN adds a stream input that chains fetches through consecutive slots.
module aes_block_reader #(
   parameter int NUM_BLOCKS = 4,
   parameter int ADDR_W     = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        blk_sel,
`ifdef AES_BLOCK_READER_STREAM_EN
   input  logic              stream,
`endif
   output logic              busy,
   output logic              mem_read_rq,
   output logic              mem_write_rq,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   output logic [127:0]      blk_data,
   output logic              blk_valid,
   input  logic              blk_ready
);

   localparam int SEL_W = $clog2(NUM_BLOCKS);

   typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

   state_t              state_q, state_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                rd_q, rd_d;
   logic                busy_q, busy_d;
   logic                valid_q, valid_d;
   logic [127:0]        data_q, data_d;

   function automatic logic [ADDR_W-1:0] slot_base(input logic [SEL_W-1:0] s);
      return ADDR_W'({s, 4'b0000});
   endfunction

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      rd_d    = rd_q;
      busy_d  = busy_q;
      valid_d = valid_q;
      data_d  = data_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               sel_d   = blk_sel[SEL_W-1:0];
               addr_d  = slot_base(blk_sel[SEL_W-1:0]);
               rd_d    = 1'b1;
               cnt_d   = 4'd0;
               busy_d  = 1'b1;
               state_d = FETCH;
            end
         end
         FETCH: begin
            // Byte k lands in bits [127-8k -: 8]; 15-k is simply ~k for a 4-bit counter.
            data_d[{~cnt_q, 3'b000} +: 8] = mem_rdata;
            cnt_d  = cnt_q + 4'd1;
            addr_d = addr_q + ADDR_W'(1);
            if (cnt_q == 4'd15) begin
               cnt_d   = 4'd0;
               rd_d    = 1'b0;
               addr_d  = '0;
               valid_d = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (blk_ready) begin
               valid_d = 1'b0;
               busy_d  = 1'b0;
               state_d = IDLE;
`ifdef AES_BLOCK_READER_STREAM_EN
               if (stream) begin
                  sel_d   = (sel_q == SEL_W'(NUM_BLOCKS - 1)) ? '0 : sel_q + SEL_W'(1);
                  addr_d  = slot_base(sel_d);
                  rd_d    = 1'b1;
                  busy_d  = 1'b1;
                  state_d = FETCH;
               end
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         sel_q   <= '0;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         rd_q    <= 1'b0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         rd_q    <= rd_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   // The reader never writes, so the RAM cannot be corrupted while it is being read.
   assign mem_write_rq = 1'b0;
   assign mem_read_rq  = rd_q;
   assign mem_addr     = addr_q;
   assign busy         = busy_q;
   assign blk_valid    = valid_q;
   assign blk_data     = data_q;

endmodule

// File: tb/tb_aes_block_reader.sv
// Bench for aes_block_reader: models the 64x8 RAM preloaded with 0x00..0x3F, drives directed block fetches.
module tb_aes_block_reader;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [1:0]   blk_sel = 2'd0;
   logic         busy, mem_read_rq, mem_write_rq, blk_valid;
   logic         blk_ready = 1'b0;
   logic [5:0]   mem_addr;
   logic [7:0]   mem_rdata;
   logic [127:0] blk_data;
`ifdef AES_BLOCK_READER_STREAM_EN
   logic         stream = 1'b0;
`endif

   logic [7:0]   ram [64];
   int           pass_cnt = 0;
   int           total_cnt = 0;

   localparam logic [127:0] BLK0 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] BLK1 = 128'h101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] BLK2 = 128'h202122232425262728292a2b2c2d2e2f;
   localparam logic [127:0] BLK3 = 128'h303132333435363738393a3b3c3d3e3f;

   aes_block_reader #(.NUM_BLOCKS(4), .ADDR_W(6)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .blk_sel      (blk_sel),
`ifdef AES_BLOCK_READER_STREAM_EN
      .stream       (stream),
`endif
      .busy         (busy),
      .mem_read_rq  (mem_read_rq),
      .mem_write_rq (mem_write_rq),
      .mem_addr     (mem_addr),
      .mem_rdata    (mem_rdata),
      .blk_data     (blk_data),
      .blk_valid    (blk_valid),
      .blk_ready    (blk_ready)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem_read_rq ? ram[mem_addr] : 8'h00;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total_cnt++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
      else pass_cnt++;
   endtask

   typedef struct {
      logic [1:0]   sel;
      int           hold;
      int           glitch;
      logic [127:0] exp;
   } vec_t;

   vec_t vecs[3];

   // Caller is at a negedge in IDLE; leaves at a negedge back in IDLE.
   task automatic run_block(input logic [1:0] sel, input int hold, input int glitch, input logic [127:0] exp);
      logic [5:0] a;
      blk_sel = sel;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      blk_sel = ~sel;
      for (int k = 0; k < 16; k++) begin
         a = {sel, 4'b0000} + 6'(k);
         chk("fetch_cycle", {busy, mem_read_rq, mem_write_rq, blk_valid, mem_addr},
             {1'b1, 1'b1, 1'b0, 1'b0, a});
         if (k == glitch) start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      chk("valid_rise", {busy, mem_read_rq, blk_valid, mem_addr}, {1'b1, 1'b0, 1'b1, 6'd0});
      chk("blk_data", blk_data, exp);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_stable", {blk_valid, mem_write_rq, blk_data}, {1'b1, 1'b0, exp});
      end
      blk_ready = 1'b1;
      @(negedge clk);
      blk_ready = 1'b0;
      chk("handshake", {busy, blk_valid, mem_read_rq}, 3'b000);
      chk("data_retained", blk_data, exp);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) ram[i] = 8'(i);
      vecs[0] = '{sel: 2'd0, hold: 0,  glitch: -1, exp: BLK0};
      vecs[1] = '{sel: 2'd3, hold: 10, glitch: -1, exp: BLK3};
      vecs[2] = '{sel: 2'd1, hold: 2,  glitch: 5,  exp: BLK1};

      @(negedge clk);
      chk("reset_state", {busy, mem_read_rq, mem_write_rq, blk_valid, mem_addr, blk_data}, '0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("idle_after_reset", {busy, mem_read_rq, blk_valid}, 3'b000);

      for (int v = 0; v < 3; v++) begin
         run_block(vecs[v].sel, vecs[v].hold, vecs[v].glitch, vecs[v].exp);
         @(negedge clk);
      end

      // Blk_ready while idle must not start anything.
      blk_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      blk_ready = 1'b0;
      chk("ready_in_idle", {busy, mem_read_rq, blk_valid}, 3'b000);

      // Asynchronous reset in the middle of a fetch.
      blk_sel = 2'd0;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      chk("pre_reset_addr", {mem_read_rq, mem_addr}, {1'b1, 6'd8});
      rst = 1'b0;
      #1;
      chk("async_reset", {busy, mem_read_rq, mem_write_rq, blk_valid, mem_addr, blk_data}, '0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      run_block(2'd2, 1, -1, BLK2);

`ifdef AES_BLOCK_READER_STREAM_EN
      begin
         logic [127:0] sexp[4];
         int lows;
         sexp[0] = BLK2; sexp[1] = BLK3; sexp[2] = BLK0; sexp[3] = BLK1;
         @(negedge clk);
         stream    = 1'b1;
         blk_ready = 1'b1;
         blk_sel   = 2'd2;
         start     = 1'b1;
         @(negedge clk);
         start = 1'b0;
         for (int b = 0; b < 4; b++) begin
            lows = 0;
            while (!blk_valid && lows < 40) begin
               lows++;
               @(negedge clk);
            end
            chk("stream_gap", 128'(lows), 128'd16);
            chk("stream_data", blk_data, sexp[b]);
            if (b == 3) stream = 1'b0;
            @(negedge clk);
         end
         blk_ready = 1'b0;
         chk("stream_end", {busy, blk_valid, mem_read_rq}, 3'b000);
      end
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/aes_block_reader.md
Name: aes_block_reader

Overview:
- Downstream consumer of the 64x8 synchronous state RAM (mem_ram_sync).
- On request, fetches one 16-byte AES-128 block from RAM, one byte per cycle, and assembles it into a 128-bit word.
- Presents the word to the AES round core over a valid/ready handshake.
- Sole read master of the RAM while busy.

Parameters:
- NUM_BLOCKS, 4, number of 16-byte block slots in RAM (64 bytes / 16); blk_sel range 0..NUM_BLOCKS-1.
- ADDR_W, 6, RAM address width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle fetch request; honoured only in IDLE.
- blk_sel  input  2  block slot to fetch; latched with start.
- busy  output  1  high in FETCH and HOLD.
- mem_read_rq  output  1  RAM read request (to read_rq).
- mem_write_rq  output  1  RAM write request (to write_rq); constant 0.
- mem_addr  output  ADDR_W  RAM address (to rw_address).
- mem_rdata  input  8  RAM read data (from read_data); combinational from the RAM array.
- blk_data  output  128  assembled block; byte at address 16*sel+k occupies bits [127-8k:120-8k].
- blk_valid  output  1  blk_data holds a complete block.
- blk_ready  input  1  AES core accepts the block.

Behaviour:
- Reset (rst=0, asynchronous, immediate):
  - state=IDLE; busy=0, mem_read_rq=0, mem_write_rq=0, mem_addr=0, blk_data=0, blk_valid=0.
  - Byte counter=0.
  - Assertion mid-FETCH or mid-HOLD aborts; the partial block is discarded.
- All outputs are registered; mem_write_rq is tied 0 so the RAM never takes a write while the reader is active.
- IDLE:
  - On an edge with start=1: latch blk_sel; set mem_addr=16*blk_sel, mem_read_rq=1, counter=0, busy=1; go to FETCH.
- FETCH:
  - Each edge captures mem_rdata into byte slot counter, then counter+1 and mem_addr+1.
  - The RAM drives read_data combinationally during the cycle read_rq is high, so each byte is sampled at the edge ending its address cycle.
  - The edge capturing byte 15 sets mem_read_rq=0, mem_addr=0, blk_valid=1; go to HOLD.
  - Latency: blk_valid rises at the 16th rising edge after the edge that sampled start.
  - mem_addr never leaves the selected 16-byte slot; no wrap across slots.
- HOLD:
  - blk_valid=1 and blk_data stable until the handshake.
  - On an edge with blk_valid&blk_ready: blk_valid=0, busy=0; go to IDLE.
  - blk_data retains its last value after the handshake.
- start is ignored when not in IDLE (no queuing).
- blk_ready outside HOLD has no effect.
- blk_data bytes update in place during FETCH; consumers qualify blk_data with blk_valid only.
- Minimum start-to-start period: 18 cycles (16 fetch, 1 handshake, 1 IDLE).

Optional Feature:
- Macro: AES_BLOCK_READER_STREAM_EN.
- Defined:
  - Adds input stream (1 bit).
  - In HOLD, on an edge with blk_valid&blk_ready and stream=1, the block goes directly to FETCH of slot (sel+1) mod NUM_BLOCKS (3 wraps to 0).
  - On that same edge: mem_read_rq=1, mem_addr=16*next, blk_valid=0, busy stays 1.
  - If stream=0 at the handshake, return to IDLE as in the base behaviour.
- Not defined:
  - No stream port; every block requires start.

Test Plan:
- RAM preloaded with bytes 0x00..0x3F; start with blk_sel=0 → mem_addr steps 0..15 with mem_read_rq=1 for exactly 16 cycles; blk_valid rises 16 edges after start; blk_data=0x000102030405060708090A0B0C0D0E0F.
- blk_sel=3, blk_ready held 0 for 10 cycles then 1 → blk_data=0x303132...3F held stable throughout HOLD; blk_valid drops 1 edge after blk_ready=1; busy=0; mem_write_rq=0 throughout.
- start pulsed again at fetch byte 5 of block 1 → ignored; mem_addr continues 0x15; result=0x101112...1F.
- rst=0 asserted at fetch byte 8 → all outputs 0 immediately; a fresh start with blk_sel=2 after release yields 0x202122...2F.
- With AES_BLOCK_READER_STREAM_EN, stream=1, blk_ready=1, start with blk_sel=2 → blocks 2, 3, 0, 1 delivered back-to-back, one every 17 cycles; blk_valid low exactly 16 cycles between blocks.
